// File: rtl/simple_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// simple_ctrl_pkg
// Shared definitions for the SIMPLE processor control path: the run/stop
// state encoding and the stop-cause codes reported on stop_cause. The decode
// block imports the same cause constants.
// -----------------------------------------------------------------------------
package simple_ctrl_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        IN_WAIT = 2'd2,
        STEP    = 2'd3
    } run_state_e;

    localparam logic [2:0] CAUSE_RESET = 3'd0;
    localparam logic [2:0] CAUSE_EXEC  = 3'd1;
    localparam logic [2:0] CAUSE_HLT   = 3'd2;
    localparam logic [2:0] CAUSE_IN    = 3'd3;
    localparam logic [2:0] CAUSE_STEP  = 3'd4;

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Synchronises the raw, bouncy exec push-button and accepts a level change
// only after DEBOUNCE_CYCLES consecutive stable synchronised samples.
//
// Ports:
//   clock       in   single clock
//   reset       in   synchronous, active-high
//   exec        in   raw push-button, high = pressed (asynchronous)
//   deb         out  debounced button level
//   press_pulse out  one-cycle pulse on each accepted press (rising deb only)
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic exec,
    output logic deb,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             s1;
    logic             s2;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= exec;
            s2    <= s1;
            deb_d <= deb;
            // Any sample agreeing with the accepted level restarts the
            // stability count, so short glitches never accumulate.
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Decoded from registers only; a release (deb falling) gives no pulse.
    assign press_pulse = deb & ~deb_d;

endmodule

// File: rtl/run_stop_controller.sv
// -----------------------------------------------------------------------------
// run_stop_controller
// Run/stop sequencer for the SIMPLE processor. Stops the core on HLT, after
// IN (with IN_DELAY cycles of IN_WAIT), on an exec press, or after one
// retired instruction in single-step mode. systemStopped gates PC update and
// register/memory writes in the datapath.
//
// Ports:
//   clock          in   single clock
//   reset          in   synchronous, active-high
//   exec           in   raw push-button (asynchronous, bouncy)
//   step_mode      in   1 = resume into single-step
//   inst_halt      in   decoded HLT valid this cycle
//   inst_in        in   decoded IN valid this cycle
//   retire         in   one-cycle pulse per completed instruction
//   systemStopped  out  1 = core frozen (state register decode)
//   exec_pulse     out  one-cycle pulse per accepted press
//   stop_cause     out  reason for the most recent stop
//   run_cycles     out  saturating count of cycles spent not stopped
// -----------------------------------------------------------------------------
module run_stop_controller
    import simple_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int IN_DELAY        = 1,
    parameter int CYCLE_W         = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exec,
    input  logic               step_mode,
    input  logic               inst_halt,
    input  logic               inst_in,
    input  logic               retire,
    output logic               systemStopped,
    output logic               exec_pulse,
    output logic [2:0]         stop_cause,
    output logic [CYCLE_W-1:0] run_cycles
);

    localparam int IN_W = (IN_DELAY < 1) ? 1 : $clog2(IN_DELAY + 1);

    run_state_e      state;
    run_state_e      state_next;
    logic            guard;
    logic            guard_next;
    logic [IN_W-1:0] in_cnt;
    logic [IN_W-1:0] in_cnt_next;
    logic [2:0]      cause_next;
    logic            exec_level;
    logic            press_pulse;

    function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
        return (v == {CYCLE_W{1'b1}}) ? v : v + CYCLE_W'(1);
    endfunction

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock       (clock),
        .reset       (reset),
        .exec        (exec),
        .deb         (exec_level),
        .press_pulse (press_pulse)
    );

    // The press pulse can only exist while the debounced level is high.
    assign exec_pulse    = press_pulse & exec_level;
    assign systemStopped = (state == STOPPED);

    always_comb begin
        state_next  = state;
        guard_next  = guard;
        in_cnt_next = in_cnt;
        cause_next  = stop_cause;
        case (state)
            STOPPED: begin
                if (exec_pulse) begin
                    state_next = step_mode ? STEP : RUNNING;
                    guard_next = 1'b1;
                end
            end
            RUNNING, STEP: begin
                // The instruction that caused the last stop is usually still
                // decoded in the first resumed cycle; the guard masks it.
                guard_next = 1'b0;
                if (inst_halt && !guard) begin
                    state_next = STOPPED;
                    cause_next = CAUSE_HLT;
                end else if (inst_in && !guard) begin
                    if (IN_DELAY == 0) begin
                        state_next = STOPPED;
                        cause_next = CAUSE_IN;
                    end else begin
                        state_next  = IN_WAIT;
                        in_cnt_next = IN_W'(IN_DELAY);
                    end
                end else if ((state == STEP) && retire) begin
                    state_next = STOPPED;
                    cause_next = CAUSE_STEP;
                end else if (exec_pulse) begin
                    state_next = STOPPED;
                    cause_next = CAUSE_EXEC;
                end
            end
            IN_WAIT: begin
                in_cnt_next = in_cnt - IN_W'(1);
                if (in_cnt == IN_W'(1)) begin
                    state_next = STOPPED;
                    cause_next = CAUSE_IN;
                end
            end
            default: begin
                state_next = STOPPED;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= STOPPED;
            guard      <= 1'b0;
            in_cnt     <= '0;
            stop_cause <= CAUSE_RESET;
            run_cycles <= '0;
        end else begin
            state      <= state_next;
            guard      <= guard_next;
            in_cnt     <= in_cnt_next;
            stop_cause <= cause_next;
            if (!systemStopped) begin
                run_cycles <= sat_inc(run_cycles);
            end
        end
    end

endmodule
